// File: rtl/hamming_noise_controller.sv
// Seedable bit-flip injector between the Hamming encoder and decoder.
// Accepts one codeword, corrupts it by 0/1/2 bits according to an LFSR, and keeps saturating statistics.
//
// state  | meaning
// IDLE   | ready for a codeword; in_ready=1
// PICK   | build the flip mask from the LFSR, register outputs, step the LFSR
// SEND   | hold outputs with out_valid=1 until out_ready
module hamming_noise_controller #(
  parameter int unsigned     WIDTH     = 16,
  parameter logic [15:0]     LFSR_SEED = 16'hACE1,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  input  logic [6:0]       rate_thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_flip_mask,
  output logic             out_changed_one,
  output logic             out_changed_two,
  input  logic             clr_counters,
  output logic [CNT_W-1:0] cnt_frames,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PICK = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [1:0]       state;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_next;
  logic [WIDTH-1:0] cap_data;
  logic [1:0]       cap_mode;
  logic [6:0]       cap_rate;

  logic [3:0]       pos1;
  logic [3:0]       pos2;
  logic [WIDTH-1:0] single_mask;
  logic [WIDTH-1:0] double_mask;
  logic [WIDTH-1:0] mask;
  logic             send_hs;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_SEND);
  assign send_hs   = (state == S_SEND) && out_ready;

  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    pos1        = lfsr[3:0];
    pos2        = (lfsr[7:4] == lfsr[3:0]) ? (lfsr[3:0] + 4'd1) : lfsr[7:4];
    single_mask = WIDTH'(1) << pos1;
    double_mask = single_mask | (WIDTH'(1) << pos2);
    mask        = '0;
    case (cap_mode)
      2'd0: mask = '0;
      2'd1: mask = single_mask;
      2'd2: mask = double_mask;
      default: begin
        if (lfsr[15:9] < cap_rate) begin
          mask = lfsr[8] ? double_mask : single_mask;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      lfsr            <= SEED_EFF;
      cap_data        <= '0;
      cap_mode        <= 2'd0;
      cap_rate        <= 7'd0;
      out_data        <= '0;
      out_flip_mask   <= '0;
      out_changed_one <= 1'b0;
      out_changed_two <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            cap_data <= in_data;
            cap_mode <= mode;
            cap_rate <= rate_thresh;
            state    <= S_PICK;
          end
        end
        S_PICK: begin
          out_data        <= cap_data ^ mask;
          out_flip_mask   <= mask;
          out_changed_one <= ($countones(mask) == 1);
          out_changed_two <= ($countones(mask) == 2);
          lfsr            <= lfsr_next;
          state           <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Clear takes priority over a coincident delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_frames <= '0;
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (clr_counters) begin
      cnt_frames <= '0;
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (send_hs) begin
      if (cnt_frames != '1) cnt_frames <= cnt_frames + CNT_W'(1);
      if (out_changed_one && (cnt_single != '1)) cnt_single <= cnt_single + CNT_W'(1);
      if (out_changed_two && (cnt_double != '1)) cnt_double <= cnt_double + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_noise_controller.sv
// Directed bench for hamming_noise_controller: default-seed instance plus a seed-0x0033 instance
// that shares its inputs to exercise the position-collision rule.
module tb_hamming_noise_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [1:0]  mode = '0;
  logic [6:0]  rate_thresh = '0;
  logic        out_ready = 1'b0;
  logic        clr_counters = 1'b0;

  logic        in_ready, out_valid, out_changed_one, out_changed_two;
  logic [15:0] out_data, out_flip_mask, cnt_frames, cnt_single, cnt_double;

  logic        d2_in_ready, d2_out_valid, d2_one, d2_two;
  logic [15:0] d2_out_data, d2_mask, d2_frames, d2_single, d2_double;

  int compared = 0;
  int mismatched = 0;
  logic [15:0] lm;
  logic [15:0] exp_mask;
  logic [15:0] dat;

  always #5 clk = ~clk;

  hamming_noise_controller #(.WIDTH(16), .LFSR_SEED(16'hACE1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .rate_thresh(rate_thresh), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flip_mask(out_flip_mask), .out_changed_one(out_changed_one),
    .out_changed_two(out_changed_two), .clr_counters(clr_counters),
    .cnt_frames(cnt_frames), .cnt_single(cnt_single), .cnt_double(cnt_double));

  hamming_noise_controller #(.WIDTH(16), .LFSR_SEED(16'h0033), .CNT_W(16)) u_dut_col (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d2_in_ready), .in_data(in_data),
    .mode(mode), .rate_thresh(rate_thresh), .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_data(d2_out_data), .out_flip_mask(d2_mask), .out_changed_one(d2_one),
    .out_changed_two(d2_two), .clr_counters(clr_counters),
    .cnt_frames(d2_frames), .cnt_single(d2_single), .cnt_double(d2_double));

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] model_mask(input logic [15:0] l, input logic [1:0] m,
                                             input logic [6:0] r);
    logic [3:0]  p1, p2;
    logic [15:0] s, d;
    p1 = l[3:0];
    p2 = l[7:4];
    if (p2 == p1) p2 = p1 + 4'd1;
    s = 16'h0001 << p1;
    d = s | (16'h0001 << p2);
    case (m)
      2'd0: return 16'h0000;
      2'd1: return s;
      2'd2: return d;
      default: return (l[15:9] < r) ? (l[8] ? d : s) : 16'h0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clr_counters = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Offer one codeword and take the handshake; returns sampled in PICK.
  task automatic accept(input logic [1:0] m, input logic [15:0] d, input logic [6:0] r);
    mode = m;
    in_data = d;
    rate_thresh = r;
    in_valid = 1'b1;
    for (int i = 0; i < 4 && !in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pick_in_ready", in_ready, 0);
    check("pick_out_valid", out_valid, 0);
  endtask

  task automatic wait_out();
    for (int i = 0; i < 4 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("out_valid_rise", out_valid, 1);
  endtask

  task automatic finish_frame();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_after_send", in_ready, 1);
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_mask", out_flip_mask, 0);
    check("rst_flags", {out_changed_one, out_changed_two}, 0);
    check("rst_counters", {cnt_frames, cnt_single, cnt_double}, 0);
    check("rst_d2_in_ready", d2_in_ready, 1);

    // Single flip from seed ACE1: pos1=1
    accept(2'd1, 16'h0000, 7'd0);
    wait_out();
    check("m1_data", out_data, 16'h0002);
    check("m1_mask", out_flip_mask, 16'h0002);
    check("m1_one", out_changed_one, 1);
    check("m1_two", out_changed_two, 0);
    check("m1_d2_valid", d2_out_valid, 1);
    check("m1_d2_mask", d2_mask, 16'h0008);
    check("m1_d2_data", d2_out_data, 16'h0008);
    finish_frame();
    check("m1_cnt_single", cnt_single, 1);
    check("m1_cnt_frames", cnt_frames, 1);
    check("m1_cnt_double", cnt_double, 0);

    // Double flip with L=E270 (pos 0,7); collision instance has L=B419 (pos 9,1)
    accept(2'd2, 16'hFFFF, 7'd0);
    wait_out();
    check("m2b_mask", out_flip_mask, 16'h0081);
    check("m2b_data", out_data, 16'hFF7E);
    check("m2b_two", out_changed_two, 1);
    check("m2b_d2_mask", d2_mask, 16'h0202);
    check("m2b_d2_data", d2_out_data, 16'hFDFD);
    finish_frame();
    check("m2b_cnt_double", cnt_double, 1);
    check("m2b_d2_counts", {d2_frames, d2_single, d2_double}, {16'd2, 16'd1, 16'd1});

    // Double flip from reset seeds; seed 0033 collides at position 3
    do_reset();
    lm = 16'hACE1;
    accept(2'd2, 16'hFFFF, 7'd0);
    wait_out();
    check("m2_data", out_data, 16'hBFFD);
    check("m2_mask", out_flip_mask, 16'h4002);
    check("m2_two", out_changed_two, 1);
    check("m2_one", out_changed_one, 0);
    check("col_mask", d2_mask, 16'h0018);
    check("col_data", d2_out_data, 16'hFFE7);
    check("col_two", d2_two, 1);
    check("col_one", d2_one, 0);
    finish_frame();
    lm = lfsr_step(lm);

    // Backpressure: hold SEND for 10 cycles
    accept(2'd1, 16'h1234, 7'd0);
    wait_out();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_data", out_data, 16'h1235);
      check("bp_mask", out_flip_mask, 16'h0001);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    check("bp_frames_held", cnt_frames, 1);
    finish_frame();
    lm = lfsr_step(lm);
    check("bp_frames", cnt_frames, 2);
    check("bp_single", cnt_single, 1);

    // LFSR did not advance during the stall: L=7138 gives pos1=8
    accept(2'd1, 16'h0000, 7'd0);
    wait_out();
    check("post_bp_mask", out_flip_mask, 16'h0100);
    finish_frame();
    lm = lfsr_step(lm);
    check("post_bp_frames", cnt_frames, 3);

    // Clear coinciding with the SEND handshake
    accept(2'd1, 16'h00F0, 7'd0);
    wait_out();
    check("clr_frame_mask", out_flip_mask, model_mask(lm, 2'd1, 7'd0));
    clr_counters = 1'b1;
    finish_frame();
    clr_counters = 1'b0;
    lm = lfsr_step(lm);
    check("clr_counters", {cnt_frames, cnt_single, cnt_double}, 0);

    // Random mode, threshold 0: never corrupts
    for (int i = 0; i < 100; i++) begin
      dat = 16'($urandom);
      accept(2'd3, dat, 7'd0);
      wait_out();
      check("r0_mask", out_flip_mask, 0);
      check("r0_data", out_data, dat);
      finish_frame();
      lm = lfsr_step(lm);
    end
    check("r0_frames", cnt_frames, 100);
    check("r0_single_double", {cnt_single, cnt_double}, 0);

    // Random mode, threshold 127: corrupts unless L[15:9]==127
    for (int i = 0; i < 20; i++) begin
      dat = 16'($urandom);
      exp_mask = model_mask(lm, 2'd3, 7'd127);
      accept(2'd3, dat, 7'd127);
      rate_thresh = 7'd0;
      mode = 2'd0;
      wait_out();
      check("r127_mask", out_flip_mask, exp_mask);
      check("r127_data", out_data, dat ^ exp_mask);
      check("r127_flags", {out_changed_one, out_changed_two},
            {($countones(exp_mask) == 1), ($countones(exp_mask) == 2)});
      finish_frame();
      lm = lfsr_step(lm);
    end
    check("r127_frames", cnt_frames, 120);

    // Asynchronous reset while in PICK
    accept(2'd2, 16'hA5A5, 7'd0);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_data", out_data, 0);
    check("arst_mask", out_flip_mask, 0);
    check("arst_counters", {cnt_frames, cnt_single, cnt_double}, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_idle_next", {in_ready, out_valid}, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
